// File: rtl/pio_sw_irq_sequencer.sv
// Avalon-MM master servicing the switch PIO: programs irq_mask, then on each irq reads
// edge_capture, clears it, reads the switch level and hands the result to a consumer.
module pio_sw_irq_sequencer #(
    parameter int unsigned           WIDTH     = 10,
    parameter logic [WIDTH-1:0]      MASK_INIT = {WIDTH{1'b1}},
    parameter int unsigned           CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             irq,
    output logic [1:0]       m_address,
    output logic             m_chipselect,
    output logic             m_write_n,
    output logic [31:0]      m_writedata,
    input  logic [31:0]      m_readdata,
    input  logic             cfg_mask_wr,
    input  logic [WIDTH-1:0] cfg_mask,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [WIDTH-1:0] evt_edges,
    output logic [WIDTH-1:0] evt_level,
    output logic [CNT_W-1:0] evt_count,
    output logic             busy
);

    localparam logic [1:0] AddrData = 2'd0;
    localparam logic [1:0] AddrMask = 2'd2;
    localparam logic [1:0] AddrEdge = 2'd3;

    // StInit is the reset state with an idle bus; StInitWr carries the irq_mask write.
    typedef enum logic [3:0] {
        StInit, StInitWr, StIdle, StMaskWr, StRdCap, StRdCapW, StClr, StRdLvl, StRdLvlW, StEmit
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic             pend_q, pend_d;
    logic [WIDTH-1:0] edges_q, edges_d;
    logic             spur_q, spur_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] evt_edges_q, evt_edges_d;
    logic [WIDTH-1:0] evt_level_q, evt_level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cs_q, cs_d;
    logic             wr_n_q, wr_n_d;
    logic [1:0]       addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [WIDTH-1:0] cap_masked;
    logic             unused_rd;

    assign unused_rd  = ^m_readdata[31:WIDTH];
    assign cap_masked = m_readdata[WIDTH-1:0] & mask_q;

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        pend_d      = pend_q;
        edges_d     = edges_q;
        spur_d      = spur_q;
        valid_d     = valid_q;
        evt_edges_d = evt_edges_q;
        evt_level_d = evt_level_q;
        cnt_d       = cnt_q;

        if (cfg_mask_wr) begin
            mask_d = cfg_mask;
            pend_d = 1'b1;
        end

        case (state_q)
            StInit:   state_d = StInitWr;
            StInitWr: state_d = StIdle;
            StIdle: begin
                if (pend_q) begin
                    state_d = StMaskWr;
                    // A request arriving on this very cycle must stay pending for a rewrite.
                    if (!cfg_mask_wr) pend_d = 1'b0;
                end else if (irq) begin
                    state_d = StRdCap;
                end
            end
            StMaskWr: state_d = StIdle;
            StRdCap:  state_d = StRdCapW;
            StRdCapW: begin
                edges_d = cap_masked;
                spur_d  = (cap_masked == '0);
                state_d = StClr;
            end
            StClr:    state_d = spur_q ? StIdle : StRdLvl;
            StRdLvl:  state_d = StRdLvlW;
            StRdLvlW: begin
                evt_level_d = m_readdata[WIDTH-1:0];
                evt_edges_d = edges_q;
                valid_d     = 1'b1;
                state_d     = StEmit;
            end
            StEmit: begin
                if (evt_ready) begin
                    valid_d = 1'b0;
                    if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                    state_d = StIdle;
                end
            end
            default:  state_d = StInit;
        endcase
    end

    // Bus outputs are registered from the next state so they line up with the state register.
    always_comb begin
        cs_d    = 1'b0;
        wr_n_d  = 1'b1;
        addr_d  = AddrData;
        wdata_d = '0;
        case (state_d)
            StInitWr, StMaskWr: begin
                cs_d    = 1'b1;
                wr_n_d  = 1'b0;
                addr_d  = AddrMask;
                wdata_d = 32'(mask_q);
            end
            StRdCap: begin
                cs_d   = 1'b1;
                addr_d = AddrEdge;
            end
            StRdCapW: addr_d = AddrEdge;
            StClr: begin
                cs_d   = 1'b1;
                wr_n_d = 1'b0;
                addr_d = AddrEdge;
            end
            StRdLvl: cs_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StInit;
            mask_q      <= MASK_INIT;
            pend_q      <= 1'b0;
            edges_q     <= '0;
            spur_q      <= 1'b0;
            valid_q     <= 1'b0;
            evt_edges_q <= '0;
            evt_level_q <= '0;
            cnt_q       <= '0;
            cs_q        <= 1'b0;
            wr_n_q      <= 1'b1;
            addr_q      <= 2'd0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            pend_q      <= pend_d;
            edges_q     <= edges_d;
            spur_q      <= spur_d;
            valid_q     <= valid_d;
            evt_edges_q <= evt_edges_d;
            evt_level_q <= evt_level_d;
            cnt_q       <= cnt_d;
            cs_q        <= cs_d;
            wr_n_q      <= wr_n_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign m_chipselect = cs_q;
    assign m_write_n    = wr_n_q;
    assign m_address    = addr_q;
    assign m_writedata  = wdata_q;
    assign evt_valid    = valid_q;
    assign evt_edges    = evt_edges_q;
    assign evt_level    = evt_level_q;
    assign evt_count    = cnt_q;
    assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_pio_sw_irq_sequencer.sv
// Bench for pio_sw_irq_sequencer: a small PIO slave model, a bus transaction log and a
// per-cycle compare process against an event/count model.
module tb_pio_sw_irq_sequencer;

    localparam int W  = 10;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          irq;
    logic [1:0]    m_address;
    logic          m_chipselect;
    logic          m_write_n;
    logic [31:0]   m_writedata;
    logic [31:0]   m_readdata = 32'h5A5A_5A5A;
    logic          cfg_mask_wr;
    logic [W-1:0]  cfg_mask;
    logic          evt_valid;
    logic          evt_ready;
    logic [W-1:0]  evt_edges;
    logic [W-1:0]  evt_level;
    logic [CW-1:0] evt_count;
    logic          busy;

    // Slave model state
    logic [W-1:0]  s_cap = '0;
    logic [W-1:0]  s_mask = '0;
    logic [W-1:0]  inject;
    logic [W-1:0]  sw_level;
    logic          irq_force;
    logic [14:0]   bus_log[$];

    // Expectation model
    logic [W-1:0]  exp_edges, exp_level;
    logic [CW-1:0] mdl_cnt;
    int            ev_seen = 0;
    logic [W-1:0]  got_edges = '0, got_level = '0;
    logic          prev_valid = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pio_sw_irq_sequencer #(.WIDTH(W), .MASK_INIT(10'h3FF), .CNT_W(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .irq          (irq),
        .m_address    (m_address),
        .m_chipselect (m_chipselect),
        .m_write_n    (m_write_n),
        .m_writedata  (m_writedata),
        .m_readdata   (m_readdata),
        .cfg_mask_wr  (cfg_mask_wr),
        .cfg_mask     (cfg_mask),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_edges    (evt_edges),
        .evt_level    (evt_level),
        .evt_count    (evt_count),
        .busy         (busy)
    );

    assign irq = (|(s_cap & s_mask)) | irq_force;

    // PIO slave: registered readdata with junk above WIDTH, write to 3 clears all edges.
    always @(posedge clk) begin
        if (m_chipselect) bus_log.push_back({~m_write_n, m_address, m_writedata[11:0]});
        if (m_chipselect && !m_write_n && m_address == 2'd3) s_cap <= '0;
        else s_cap <= s_cap | inject;
        if (m_chipselect && !m_write_n && m_address == 2'd2) s_mask <= m_writedata[W-1:0];
        if (m_chipselect && m_write_n) begin
            case (m_address)
                2'd0:    m_readdata <= {22'h3F_FFFF, sw_level};
                2'd2:    m_readdata <= {22'h3F_FFFF, s_mask};
                2'd3:    m_readdata <= {22'h3F_FFFF, s_cap};
                default: m_readdata <= 32'hFFFF_FFFF;
            endcase
        end else begin
            m_readdata <= 32'h5A5A_5A5A;
        end
    end

    // Accepted events counted with saturation at the counter's full scale.
    always @(posedge clk or posedge reset) begin
        if (reset) mdl_cnt <= '0;
        else if (evt_valid && evt_ready && int'(mdl_cnt) < (1 << CW) - 1) mdl_cnt <= mdl_cnt + 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            check("rst_valid", 32'(evt_valid), 32'd0);
            check("rst_count", 32'(evt_count), 32'd0);
            check("rst_cs", 32'(m_chipselect), 32'd0);
        end else begin
            check("count_model", 32'(evt_count), 32'(mdl_cnt));
            if (evt_valid) begin
                check("evt_edges", 32'(evt_edges), 32'(exp_edges));
                check("evt_level", 32'(evt_level), 32'(exp_level));
                check("bus_quiet_in_emit", 32'(m_chipselect), 32'd0);
                if (!prev_valid) begin
                    ev_seen++;
                    got_edges = evt_edges;
                    got_level = evt_level;
                end
            end
        end
        prev_valid = evt_valid;
    end

    function automatic logic [14:0] ent(input logic wr, input logic [1:0] a, input logic [11:0] d);
        return {wr, a, d};
    endfunction

    task automatic inject_edges(input logic [W-1:0] v);
        @(negedge clk) inject = v;
        @(negedge clk) inject = '0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!evt_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        if (!evt_valid) check("wait_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_rdlvl();
        int n = 0;
        while (!(m_chipselect && m_write_n && m_address == 2'd0) && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (n >= 30) check("wait_rdlvl_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_log(input int target);
        int n = 0;
        while (bus_log.size() < target && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check("wait_log_timeout", 32'(bus_log.size()), 32'(target));
    endtask

    initial begin
        int base, ev0, lat;
        reset = 1'b1; inject = '0; sw_level = '0; irq_force = 1'b0;
        cfg_mask_wr = 1'b0; cfg_mask = '0; evt_ready = 1'b0;
        exp_edges = '0; exp_level = '0;
        repeat (3) @(negedge clk);

        // Reset release: exactly one irq_mask write of 0x3FF, then idle.
        base = bus_log.size();
        #2 reset = 1'b0;
        repeat (6) @(negedge clk);
        check("init_nwrites", 32'(bus_log.size() - base), 32'd1);
        check("init_write", 32'(bus_log[base]), 32'(ent(1'b1, 2'd2, 12'h3FF)));
        check("init_busy", 32'(busy), 32'd0);
        check("init_bus_idle", {m_chipselect, m_write_n, m_address, m_writedata[27:0]}, 32'h4000_0000);

        // Basic event: edges 0x005, level 0x1A5, consumer always ready.
        evt_ready = 1'b1; exp_edges = 10'h005; exp_level = 10'h1A5; sw_level = 10'h1A5;
        base = bus_log.size(); ev0 = ev_seen;
        inject_edges(10'h005);
        wait_valid(lat);
        check("latency", 32'(lat), 32'd6);
        repeat (4) @(negedge clk);
        check("ev1_nbus", 32'(bus_log.size() - base), 32'd3);
        check("ev1_rd_cap", 32'(bus_log[base]), 32'(ent(1'b0, 2'd3, 12'h000)));
        check("ev1_clr", 32'(bus_log[base+1]), 32'(ent(1'b1, 2'd3, 12'h000)));
        check("ev1_rd_lvl", 32'(bus_log[base+2]), 32'(ent(1'b0, 2'd0, 12'h000)));
        check("ev1_edges", 32'(got_edges), 32'h005);
        check("ev1_level", 32'(got_level), 32'h1A5);
        check("ev1_count", 32'(evt_count), 32'd1);
        check("ev1_nevents", 32'(ev_seen - ev0), 32'd1);

        // Back-pressure: valid and data stay put for 10 cycles with no bus traffic.
        evt_ready = 1'b0; exp_edges = 10'h2A0; exp_level = 10'h0F3; sw_level = 10'h0F3;
        inject_edges(10'h2A0);
        wait_valid(lat);
        base = bus_log.size();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(evt_valid), 32'd1);
            check("hold_count", 32'(evt_count), 32'd1);
        end
        check("hold_nbus", 32'(bus_log.size() - base), 32'd0);
        evt_ready = 1'b1;
        @(negedge clk);
        check("accept_valid", 32'(evt_valid), 32'd0);
        check("accept_count", 32'(evt_count), 32'd2);

        // Mask update during RDLVL with a pending irq: mask write precedes the next capture,
        // and a fully masked capture still gets cleared without an event.
        exp_edges = 10'h0C3; exp_level = 10'h155; sw_level = 10'h155;
        repeat (2) @(negedge clk);
        base = bus_log.size(); ev0 = ev_seen;
        inject_edges(10'h0C3);
        wait_rdlvl();
        cfg_mask_wr = 1'b1; cfg_mask = 10'h00F; inject = 10'h0F0; irq_force = 1'b1;
        @(negedge clk);
        cfg_mask_wr = 1'b0; inject = '0;
        wait_log(base + 6);
        irq_force = 1'b0;
        repeat (6) @(negedge clk);
        check("mask_nbus", 32'(bus_log.size() - base), 32'd6);
        check("mask_wr", 32'(bus_log[base+3]), 32'(ent(1'b1, 2'd2, 12'h00F)));
        check("spur_rd_cap", 32'(bus_log[base+4]), 32'(ent(1'b0, 2'd3, 12'h000)));
        check("spur_clr", 32'(bus_log[base+5]), 32'(ent(1'b1, 2'd3, 12'h000)));
        check("mask_nevents", 32'(ev_seen - ev0), 32'd1);
        check("mask_ev_edges", 32'(got_edges), 32'h0C3);
        check("mask_count", 32'(evt_count), 32'd3);

        // Saturation and masking of captured edges by the new mask.
        exp_edges = 10'h005; exp_level = 10'h2CC; sw_level = 10'h2CC;
        ev0 = ev_seen;
        inject_edges(10'h3F5);
        wait_valid(lat);
        repeat (4) @(negedge clk);
        check("sat_nevents", 32'(ev_seen - ev0), 32'd1);
        check("sat_edges", 32'(got_edges), 32'h005);
        check("sat_count", 32'(evt_count), 32'd3);

        // Reset during RDLVLW: event dropped, mask back to 0x3FF and rewritten.
        exp_edges = 10'h001; exp_level = 10'h111; sw_level = 10'h111;
        ev0 = ev_seen;
        inject_edges(10'h001);
        wait_rdlvl();
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        check("rst_mid_valid", 32'(evt_valid), 32'd0);
        check("rst_mid_count", 32'(evt_count), 32'd0);
        base = bus_log.size();
        #2 reset = 1'b0;
        repeat (8) @(negedge clk);
        check("reinit_nwrites", 32'(bus_log.size() - base), 32'd1);
        check("reinit_write", 32'(bus_log[base]), 32'(ent(1'b1, 2'd2, 12'h3FF)));
        check("reinit_busy", 32'(busy), 32'd0);
        check("reinit_nevents", 32'(ev_seen - ev0), 32'd0);
        check("reinit_count", 32'(evt_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pio_sw_irq_sequencer.md
Name: pio_sw_irq_sequencer

Overview:
- Hardware Avalon-MM master that services the 10-bit switch PIO slave without CPU involvement.
- After reset it programs the slave's irq_mask.
- On each irq it reads edge_capture, clears it, then reads the live switch level.
- It presents the captured edges and the level to a downstream consumer over a valid/ready handshake.
- It sits between the switch PIO slave port and the application logic that reacts to switch changes.

Parameters:
- WIDTH, 10: switch count; matches the PIO data width.
- MASK_INIT, {WIDTH{1'b1}}: irq_mask value written after reset.
- CNT_W, 16: width of the delivered-event counter.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- irq  in  1  PIO interrupt output
- m_address  out  2  slave word address (0=data, 2=irq_mask, 3=edge_capture)
- m_chipselect  out  1  slave select
- m_write_n  out  1  active-low write strobe
- m_writedata  out  32  write data, zero-extended from WIDTH
- m_readdata  in  32  slave readdata; registered, 1-cycle latency, no waitrequest
- cfg_mask_wr  in  1  one-cycle pulse requesting a new irq_mask
- cfg_mask  in  WIDTH  new mask value, sampled when cfg_mask_wr=1
- evt_valid  out  1  event available
- evt_ready  in  1  consumer accepts the event
- evt_edges  out  WIDTH  edge_capture & current mask
- evt_level  out  WIDTH  switch level read after the clear
- evt_count  out  CNT_W  saturating count of accepted events
- busy  out  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high, ports named clk and reset.
- Reset values:
  - State = INIT. Mask register = MASK_INIT; pending flag = 0.
  - Bus idle: chipselect=0, write_n=1, address=0, writedata=0.
  - evt_valid=0, evt_edges=0, evt_level=0, evt_count=0.
- Bus driving rule: idle values are driven in every state not listed below. Outputs are registered from the state, so bus signals change only on clk edges.
- States:
  - INIT: one write cycle (cs=1, wr_n=0, addr=2, wdata=mask) -> IDLE.
  - IDLE: if pending -> MASKWR; else if irq=1 -> RDCAP; else stay.
  - MASKWR: write cycle to addr 2 with the pending mask; clear pending -> IDLE.
  - RDCAP: cs=1, wr_n=1, addr=3 -> RDCAPW.
  - RDCAPW: addr held at 3; latch m_readdata[WIDTH-1:0] & mask into an edges register.
    - If result = 0 (spurious or masked edge) -> CLR, then IDLE, with no event.
    - Else -> CLR.
  - CLR: write cycle to addr 3, wdata=0. The slave clears all bits. -> RDLVL, or IDLE in the spurious case.
  - RDLVL: read addr 0 -> RDLVLW.
  - RDLVLW: latch m_readdata[WIDTH-1:0] into evt_level; load evt_edges; set evt_valid=1 -> EMIT.
  - EMIT: hold evt_valid and data stable until evt_ready=1.
    - Acceptance happens on the edge where valid&ready are both high.
    - On acceptance: evt_valid=0, evt_count+1 (held at all-ones once saturated) -> IDLE.
- Latency: irq rising while IDLE -> evt_valid high on the 6th clk edge after irq is first sampled (RDCAP..RDLVLW, plus entry).
- Minimum turnaround: 1 IDLE cycle between events. An irq still high in IDLE restarts the read sequence.
- Edge clearing: the CLR write clears all edge bits.
  - Edges arriving between RDCAPW and CLR are lost.
  - Edges arriving after CLR re-raise irq and produce a new event.
- cfg_mask_wr handling:
  - Accepted in any state. Latest value wins into a one-deep pending register; pending=1.
  - The mask register updates immediately on acceptance.
  - The slave write occurs only from IDLE, so a sequence in flight completes first.
  - Priority in IDLE: pending mask > irq.
- evt_edges uses the mask value at RDCAPW.
- Reset asserted mid-sequence:
  - Immediate return to INIT and idle bus; the event in flight is discarded.
  - Mask returns to MASK_INIT and is rewritten to the slave.
- m_readdata bits above WIDTH are ignored.

Test Plan:
- Reset release -> exactly one write: addr=2, wdata=0x3FF, one cycle; then IDLE with bus idle, busy=0.
- Slave edge_capture=0x005, level=0x1A5, irq pulse, evt_ready=1 -> bus order: read 3, write 3 (wdata 0), read 0. Then evt_edges=0x005, evt_level=0x1A5, evt_count=1.
- evt_ready=0 for 10 cycles during EMIT -> evt_valid and data stable throughout; no bus activity; count increments only on the accepting cycle.
- cfg_mask_wr=0x00F during RDLVL, with irq also pending afterwards -> MASKWR write of 0x00F occurs before the next RDCAP. A subsequent capture of 0x0F0 yields no event, and the clear write still occurs.
- Preload evt_count to 0xFFFE via 3 events from a forced initial value (or CNT_W=2: 4 events) -> count saturates at all-ones and does not wrap.
- Assert reset during RDLVLW -> evt_valid stays 0; after release, the INIT write of MASK_INIT reappears and the count reads 0.
